// File: rtl/frame_scheduler.sv
// Programmable bit/word/frame timing sequencer with start/stop FSM and shadowed config registers.
// Optional FRAME_SYNC_EN adds sync_in (external frame resync) and the resync pulse output.
module frame_scheduler #(
  parameter int unsigned BIT_DIV_DEF     = 126,
  parameter int unsigned WORD_BITS_DEF   = 10,
  parameter int unsigned FRAME_WORDS_DEF = 8
) (
  input  logic        clk80,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic        busy,
  output logic        bit_clk,
  output logic        bit_tick,
  output logic        word_tick,
  output logic        frame_tick,
  output logic [7:0]  bit_idx,
  output logic [7:0]  word_idx
`ifdef FRAME_SYNC_EN
  ,
  input  logic        sync_in,
  output logic        resync
`endif
);

  localparam logic [15:0] BIT_DIV_INIT     = 16'(BIT_DIV_DEF);
  localparam logic [7:0]  WORD_BITS_INIT   = 8'(WORD_BITS_DEF);
  localparam logic [7:0]  FRAME_WORDS_INIT = 8'(FRAME_WORDS_DEF);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] bit_div, shadow_bit_div;
  logic [7:0]  word_bits, shadow_word_bits;
  logic [7:0]  frame_words, shadow_frame_words;
  logic        running;
  logic        sync_clr;

  assign running = (state != IDLE);
  assign busy    = running;
  assign bit_clk = running && (cnt >= (bit_div >> 1));

  // A resync edge suppresses any tick of the frame it truncates.
  assign bit_tick   = running && !sync_clr && (cnt == bit_div - 16'd1);
  assign word_tick  = bit_tick && (bit_idx == word_bits - 8'd1);
  assign frame_tick = word_tick && (word_idx == frame_words - 8'd1);

`ifdef FRAME_SYNC_EN
  logic [2:0] sync_sr;
  assign sync_clr = running && sync_sr[1] && !sync_sr[2];

  always_ff @(posedge clk80) begin
    if (reset) begin
      sync_sr <= '0;
      resync  <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[1:0], sync_in};
      resync  <= sync_clr;
    end
  end
`else
  assign sync_clr = 1'b0;
`endif

  always_ff @(posedge clk80) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      bit_idx            <= '0;
      word_idx           <= '0;
      cfg_ack            <= 1'b0;
      cfg_err            <= 1'b0;
      bit_div            <= BIT_DIV_INIT;
      word_bits          <= WORD_BITS_INIT;
      frame_words        <= FRAME_WORDS_INIT;
      shadow_bit_div     <= BIT_DIV_INIT;
      shadow_word_bits   <= WORD_BITS_INIT;
      shadow_frame_words <= FRAME_WORDS_INIT;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: if (cfg_wdata >= 16'd2) begin
            shadow_bit_div <= cfg_wdata;
            cfg_ack        <= 1'b1;
          end else cfg_err <= 1'b1;
          2'd1: if (cfg_wdata[7:0] != 8'd0) begin
            shadow_word_bits <= cfg_wdata[7:0];
            cfg_ack          <= 1'b1;
          end else cfg_err <= 1'b1;
          2'd2: if (cfg_wdata[7:0] != 8'd0) begin
            shadow_frame_words <= cfg_wdata[7:0];
            cfg_ack            <= 1'b1;
          end else cfg_err <= 1'b1;
          default: cfg_err <= 1'b1;
        endcase
      end

      // Active copy takes the pre-write shadow value, so a write on frame_tick waits a frame.
      if (!running || frame_tick) begin
        bit_div     <= shadow_bit_div;
        word_bits   <= shadow_word_bits;
        frame_words <= shadow_frame_words;
      end

      if (state == IDLE) begin
        cnt      <= '0;
        bit_idx  <= '0;
        word_idx <= '0;
        if (start && !stop) state <= RUN;
      end else begin
        if (sync_clr) begin
          cnt      <= '0;
          bit_idx  <= '0;
          word_idx <= '0;
        end else if (bit_tick) begin
          cnt     <= '0;
          bit_idx <= word_tick ? 8'd0 : bit_idx + 8'd1;
          if (word_tick) word_idx <= frame_tick ? 8'd0 : word_idx + 8'd1;
        end else begin
          cnt <= cnt + 16'd1;
        end

        if (state == RUN) begin
          if (stop) state <= DRAIN;
        end else if (frame_tick) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule
